// File: rtl/uart_rx_word_pkg.sv
// Shared definitions for the UART word receiver: byte FSM states, 8N1 frame levels
// and a helper that sizes counters from parameter values.
package uart_rx_word_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_word_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM, false-start rejection
// and stop-bit framing check. o_idle drops in the cycle a start edge is seen.
module uart_rx_word_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = 625
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_val,
  output logic       o_frame_err,
  output logic       o_idle
);

  localparam int             CW      = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_e     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          wait_high;
  logic          start_seen;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // After a framing error the line may still be low; no new start until it returns high.
  assign start_seen = !wait_high && (rx_sync == START_LVL);
  assign o_idle     = (state == ST_IDLE) && !start_seen;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      wait_high   <= 1'b0;
      o_byte      <= '0;
      o_byte_val  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_byte_val  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (rx_sync == LINE_IDLE) wait_high <= 1'b0;
          if (start_seen) state <= ST_START;
        end
        ST_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= (rx_sync == START_LVL) ? ST_DATA : ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
            if (rx_sync == STOP_LVL) begin
              o_byte     <= shreg;
              o_byte_val <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              wait_high   <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver that packs BYTES_PER_WORD consecutive bytes into one word, dropping
// a partial word on framing error or when the line idles too long mid-word.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 625,
  parameter int BYTES_PER_WORD = 2,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_uart_rx,
  output logic [7:0]                  o_rxbyte,
  output logic                        o_rxbyteval,
  output logic [8*BYTES_PER_WORD-1:0] o_word,
  output logic                        o_wordval,
  output logic                        o_frame_err,
  output logic                        o_timeout_err
);

  localparam int              WW       = 8 * BYTES_PER_WORD;
  localparam int              BCW      = cnt_width(BYTES_PER_WORD);
  localparam logic [BCW-1:0]  BYTE_LST = BCW'(BYTES_PER_WORD - 1);
  localparam int              TMO_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int              TCW      = cnt_width(TMO_CYC);
  localparam logic [TCW-1:0]  TMO_LST  = TCW'(TMO_CYC - 1);

  logic           rx_idle;
  logic [WW-1:0]  word_next;
  logic [BCW-1:0] byte_cnt;
  logic [TCW-1:0] idle_cnt;
  logic           idle_run;

  uart_rx_word_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_uart_rx  (i_uart_rx),
    .o_byte     (o_rxbyte),
    .o_byte_val (o_rxbyteval),
    .o_frame_err(o_frame_err),
    .o_idle     (rx_idle)
  );

  // Only the bytes that survive the next shift are stored; the oldest falls off the end.
  if (BYTES_PER_WORD == 1) begin : g_single
    assign word_next = o_rxbyte;
  end else begin : g_multi
    logic [WW-9:0] keep_sr;
    if (MSB_FIRST) begin : g_msb
      assign word_next = {keep_sr, o_rxbyte};
    end else begin : g_lsb
      assign word_next = {o_rxbyte, keep_sr};
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        keep_sr <= '0;
      end else if (o_rxbyteval) begin
        keep_sr <= MSB_FIRST ? word_next[WW-9:0] : word_next[WW-1:8];
      end
    end
  end

  assign idle_run = rx_idle && (byte_cnt != '0) && !o_rxbyteval;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt      <= '0;
      idle_cnt      <= '0;
      o_word        <= '0;
      o_wordval     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      o_wordval     <= 1'b0;
      o_timeout_err <= 1'b0;
      if (o_frame_err) begin
        byte_cnt <= '0;
      end else if (o_rxbyteval) begin
        if (byte_cnt == BYTE_LST) begin
          byte_cnt  <= '0;
          o_word    <= word_next;
          o_wordval <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
        end
      end else if (idle_run && idle_cnt == TMO_LST) begin
        byte_cnt      <= '0;
        o_timeout_err <= 1'b1;
      end

      // A start edge clears rx_idle in the same cycle, so it always beats the timeout.
      if (idle_run) begin
        idle_cnt <= (idle_cnt == TMO_LST) ? '0 : idle_cnt + TCW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: two instances (2-byte MSB-first, 4-byte LSB-first) share one
// serial line; directed vectors, corner sequences and a random byte stream with a model.
`timescale 1ns/100ps
module tb_uart_rx_word;

  localparam int CPB      = 16;
  localparam int TMO_BITS = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line = 1'b1;

  logic [7:0]  a_rxbyte, b_rxbyte;
  logic        a_rxbyteval, b_rxbyteval;
  logic [15:0] a_word;
  logic [31:0] b_word;
  logic        a_wordval, b_wordval, a_frame_err, b_frame_err, a_timeout_err, b_timeout_err;

  always #20.5 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(2), .MSB_FIRST(1'b1), .TIMEOUT_BITS(TMO_BITS)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line),
    .o_rxbyte(a_rxbyte), .o_rxbyteval(a_rxbyteval), .o_word(a_word), .o_wordval(a_wordval),
    .o_frame_err(a_frame_err), .o_timeout_err(a_timeout_err)
  );

  uart_rx_word #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(4), .MSB_FIRST(1'b0), .TIMEOUT_BITS(TMO_BITS)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(line),
    .o_rxbyte(b_rxbyte), .o_rxbyteval(b_rxbyteval), .o_word(b_word), .o_wordval(b_wordval),
    .o_frame_err(b_frame_err), .o_timeout_err(b_timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  byte_log[$];
  logic [15:0] word_a_log[$];
  logic [31:0] word_b_log[$];
  int frame_a = 0, tmo_a = 0, frame_b = 0, tmo_b = 0, pulse_viol = 0;
  logic [3:0] prev_a = '0, prev_b = '0;

  // Pulse logger plus the always-true rules: one-cycle pulses, byte/frame exclusivity.
  always @(negedge clk) begin
    logic [3:0] cur_a, cur_b;
    if (a_rxbyteval) byte_log.push_back(a_rxbyte);
    if (a_wordval) word_a_log.push_back(a_word);
    if (b_wordval) word_b_log.push_back(b_word);
    if (a_frame_err) frame_a++;
    if (a_timeout_err) tmo_a++;
    if (b_frame_err) frame_b++;
    if (b_timeout_err) tmo_b++;
    cur_a = {a_rxbyteval, a_wordval, a_frame_err, a_timeout_err};
    cur_b = {b_rxbyteval, b_wordval, b_frame_err, b_timeout_err};
    if ((cur_a & prev_a) != 4'b0 || (cur_b & prev_b) != 4'b0) pulse_viol++;
    if ((a_frame_err && a_rxbyteval) || (b_frame_err && b_rxbyteval)) pulse_viol++;
    if (a_rxbyteval != b_rxbyteval || (b_rxbyteval && b_rxbyte != a_rxbyte)) pulse_viol++;
    prev_a = cur_a;
    prev_b = cur_b;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic clear_logs();
    byte_log.delete();
    word_a_log.delete();
    word_b_log.delete();
    frame_a = 0;
    tmo_a   = 0;
    frame_b = 0;
    tmo_b   = 0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // One 8N1 frame, optionally with a low stop bit, followed by gap_bits of idle line.
  task automatic applyStimulus(input logic [7:0] data, input bit bad_stop, input int gap_bits);
    line = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      line = data[i];
      wait_bits(1);
    end
    line = !bad_stop;
    wait_bits(1);
    line = 1'b1;
    wait_bits(gap_bits);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b[6];
    bit          bad[6];
    int          gap[6];
    int          na;
    logic [15:0] wa[3];
    int          nb;
    logic [31:0] wb;
    int          nfr;
    int          ntmo;
    logic [15:0] fin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  rb[40];
    bit          rbad[40];
    int          rgap[40];
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [7:0]  pa[2];
    logic [7:0]  pb[4];
    logic [7:0]  d;
    logic [31:0] w;
    int          ca, cb, efr, eta, etb;

    vecs[0] = '{2, '{8'hB1, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 2, 0, 0, 0, 0},
                1, '{16'hB10A, 16'h0, 16'h0}, 0, 32'h0, 0, 0, 16'hB10A};
    vecs[1] = '{4, '{8'hB1, 8'h0A, 8'h79, 8'h12, 8'h00, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 2, 0, 0},
                2, '{16'hB10A, 16'h7912, 16'h0}, 1, 32'h12790AB1, 0, 0, 16'h7912};
    vecs[2] = '{3, '{8'h55, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00}, '{1, 0, 0, 0, 0, 0}, '{2, 0, 2, 0, 0, 0},
                1, '{16'h3456, 16'h0, 16'h0}, 0, 32'h0, 1, 0, 16'h3456};
    vecs[3] = '{3, '{8'hB1, 8'h0A, 8'hA5, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 25, 0, 0, 0},
                1, '{16'hB10A, 16'h0, 16'h0}, 0, 32'h0, 0, 1, 16'hB10A};
    vecs[4] = '{5, '{8'hB1, 8'h0A, 8'hA5, 8'h12, 8'h34, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 25, 0, 2, 0},
                2, '{16'hB10A, 16'h1234, 16'h0}, 0, 32'h0, 0, 1, 16'h1234};
    vecs[5] = '{3, '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 2, 0, 0, 0},
                1, '{16'h1122, 16'h0, 16'h0}, 0, 32'h0, 0, 0, 16'h1122};
    vecs[6] = '{2, '{8'hB1, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{15, 2, 0, 0, 0, 0},
                1, '{16'hB10A, 16'h0, 16'h0}, 0, 32'h0, 0, 0, 16'hB10A};
    vecs[7] = '{5, '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 2, 0},
                2, '{16'hAABB, 16'hCCDD, 16'h0}, 1, 32'hDDCCBBAA, 0, 0, 16'hCCDD};

    $display("[TB] start");
    do_reset();
    checkOutput("reset a_rxbyte", 64'(a_rxbyte), 64'h0);
    checkOutput("reset a_word", 64'(a_word), 64'h0);
    checkOutput("reset b_word", 64'(b_word), 64'h0);
    checkOutput("reset pulses", 64'({a_rxbyteval, a_wordval, a_frame_err, a_timeout_err}), 64'h0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int j = 0; j < vecs[i].n; j++) applyStimulus(vecs[i].b[j], vecs[i].bad[j], vecs[i].gap[j]);
      repeat (4) @(negedge clk);
      checkOutput($sformatf("v%0d a_nwords", i), 64'(word_a_log.size()), 64'(vecs[i].na));
      for (int k = 0; k < vecs[i].na; k++)
        checkOutput($sformatf("v%0d a_word%0d", i, k),
                    (k < word_a_log.size()) ? 64'(word_a_log[k]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(vecs[i].wa[k]));
      checkOutput($sformatf("v%0d b_nwords", i), 64'(word_b_log.size()), 64'(vecs[i].nb));
      if (vecs[i].nb > 0)
        checkOutput($sformatf("v%0d b_word", i),
                    (word_b_log.size() > 0) ? 64'(word_b_log[0]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(vecs[i].wb));
      checkOutput($sformatf("v%0d frame_err", i), 64'(frame_a), 64'(vecs[i].nfr));
      checkOutput($sformatf("v%0d timeout_err", i), 64'(tmo_a), 64'(vecs[i].ntmo));
      checkOutput($sformatf("v%0d final_word", i), 64'(a_word), 64'(vecs[i].fin));
    end

    // A short low glitch must be rejected without disturbing the next word.
    do_reset();
    line = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    line = 1'b1;
    wait_bits(2);
    checkOutput("glitch no_pulses", 64'(byte_log.size() + frame_a + tmo_a + word_a_log.size()), 64'h0);
    applyStimulus(8'h12, 1'b0, 0);
    applyStimulus(8'h34, 1'b0, 2);
    checkOutput("glitch nwords", 64'(word_a_log.size()), 64'h1);
    checkOutput("glitch word", 64'(a_word), 64'h1234);

    // Reset in the middle of a frame, with a partial word pending, aborts both.
    do_reset();
    applyStimulus(8'hB1, 1'b0, 0);
    applyStimulus(8'h0A, 1'b0, 0);
    applyStimulus(8'h77, 1'b0, 2);
    d = 8'h5A;
    line = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      line = d[i];
      wait_bits(1);
    end
    rst = 1'b1;
    clear_logs();
    for (int i = 4; i < 8; i++) begin
      line = d[i];
      wait_bits(1);
    end
    line = 1'b1;
    wait_bits(1);
    checkOutput("rst_mid word", 64'(a_word), 64'h0);
    checkOutput("rst_mid rxbyte", 64'(a_rxbyte), 64'h0);
    rst = 1'b0;
    wait_bits(2);
    checkOutput("rst_mid no_pulses", 64'(byte_log.size() + frame_a + tmo_a + word_a_log.size()), 64'h0);
    applyStimulus(8'h12, 1'b0, 0);
    applyStimulus(8'h34, 1'b0, 2);
    checkOutput("rst_mid nwords", 64'(word_a_log.size()), 64'h1);
    checkOutput("rst_mid word_after", 64'(a_word), 64'h1234);

    // Random stream: bytes, occasional bad stop bits, occasional long idle gaps.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rb[i]   = 8'($urandom);
      rbad[i] = ($urandom_range(0, 9) == 0);
      rgap[i] = ($urandom_range(0, 7) == 0) ? 25 : int'($urandom_range(0, 3));
      if (rbad[i] && rgap[i] == 0) rgap[i] = 1;
      if (i == 39 && rgap[i] > 3) rgap[i] = 2;
      applyStimulus(rb[i], rbad[i], rgap[i]);
    end
    repeat (4) @(negedge clk);

    ca = 0; cb = 0; efr = 0; eta = 0; etb = 0;
    for (int i = 0; i < 40; i++) begin
      if (rbad[i]) begin
        efr++;
        ca = 0;
        cb = 0;
      end else begin
        exp_bytes.push_back(rb[i]);
        pa[ca] = rb[i];
        ca++;
        if (ca == 2) begin
          exp_a.push_back({pa[0], pa[1]});
          ca = 0;
        end
        pb[cb] = rb[i];
        cb++;
        if (cb == 4) begin
          w = 0;
          for (int k = 0; k < 4; k++) w = w + (32'(pb[k]) << (8 * k));
          exp_b.push_back(w);
          cb = 0;
        end
      end
      if (rgap[i] >= TMO_BITS) begin
        if (ca > 0) begin eta++; ca = 0; end
        if (cb > 0) begin etb++; cb = 0; end
      end
    end

    checkOutput("rand nbytes", 64'(byte_log.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      checkOutput($sformatf("rand byte%0d", i),
                  (i < byte_log.size()) ? 64'(byte_log[i]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(exp_bytes[i]));
    checkOutput("rand a_nwords", 64'(word_a_log.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++)
      checkOutput($sformatf("rand a_word%0d", i),
                  (i < word_a_log.size()) ? 64'(word_a_log[i]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(exp_a[i]));
    checkOutput("rand b_nwords", 64'(word_b_log.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size(); i++)
      checkOutput($sformatf("rand b_word%0d", i),
                  (i < word_b_log.size()) ? 64'(word_b_log[i]) : 64'hDEAD_BEEF_DEAD_BEEF, 64'(exp_b[i]));
    checkOutput("rand a_frame", 64'(frame_a), 64'(efr));
    checkOutput("rand b_frame", 64'(frame_b), 64'(efr));
    checkOutput("rand a_timeout", 64'(tmo_a), 64'(eta));
    checkOutput("rand b_timeout", 64'(tmo_b), 64'(etb));
    checkOutput("pulse rules", 64'(pulse_viol), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
